// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply and restoring
// divide on operand magnitudes, with sign correction applied in one final cycle.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_operand_a,
   input  logic [WIDTH-1:0] i_operand_b,
   input  logic             i_hi_we,
   input  logic             i_lo_we,
   input  logic [WIDTH-1:0] i_wr_data,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic             o_busy,
   output logic             o_done
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ITER,
      S_FINISH
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic               w_busy;

   logic [CW-1:0]      r_cnt;
   logic               r_is_div;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_div_zero;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH-1:0]   r_raw_a;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;

   logic               w_signed;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_abs;
   logic [WIDTH-1:0]   w_b_abs;

   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_next;
   logic [WIDTH:0]     w_shift;
   logic               w_ge;
   logic [WIDTH-1:0]   w_diff;
   logic [WIDTH-1:0]   w_rem_next;

   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   // Operand conditioning: op[0]=1 selects the unsigned variants.
   assign w_signed = ~i_op[0];
   assign w_a_neg  = w_signed & i_operand_a[WIDTH-1];
   assign w_b_neg  = w_signed & i_operand_b[WIDTH-1];
   assign w_a_abs  = w_a_neg ? (~i_operand_a + 1'b1) : i_operand_a;
   assign w_b_abs  = w_b_neg ? (~i_operand_b + 1'b1) : i_operand_b;

   // Multiply step: the low half of r_acc holds the multiplier and shifts out
   // one bit per step while the product grows in from the top.
   assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
   assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Divide step: the low half of r_acc holds the dividend and collects
   // quotient bits; the shifted remainder needs one extra bit for the compare.
   assign w_shift    = {r_rem, r_acc[WIDTH-1]};
   assign w_ge       = (w_shift >= {1'b0, r_opnd});
   assign w_diff     = w_shift[WIDTH-1:0] - r_opnd;
   assign w_rem_next = w_ge ? w_diff : w_shift[WIDTH-1:0];

   assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
   assign w_quo  = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
   assign w_rem  = r_neg_r ? (~r_rem + 1'b1) : r_rem;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_busy       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_next = S_ITER;
            end
         end
         S_ITER: begin
            w_busy = 1'b1;
            if (r_cnt == LAST_CNT) begin
               w_state_next = S_FINISH;
            end
         end
         S_FINISH: begin
            w_busy       = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cnt      <= '0;
         r_is_div   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_div_zero <= 1'b0;
         r_opnd     <= '0;
         r_raw_a    <= '0;
         r_acc      <= '0;
         r_rem      <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= (r_state == S_FINISH);
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  // An accepted start takes priority over MTHI/MTLO.
                  r_cnt      <= '0;
                  r_is_div   <= i_op[1];
                  r_neg_q    <= w_a_neg ^ w_b_neg;
                  r_neg_r    <= w_a_neg;
                  r_div_zero <= (i_operand_b == '0);
                  r_raw_a    <= i_operand_a;
                  r_rem      <= '0;
                  if (i_op[1]) begin
                     r_opnd <= w_b_abs;
                     r_acc  <= {{WIDTH{1'b0}}, w_a_abs};
                  end else begin
                     r_opnd <= w_a_abs;
                     r_acc  <= {{WIDTH{1'b0}}, w_b_abs};
                  end
               end else begin
                  if (i_hi_we) begin
                     r_hi <= i_wr_data;
                  end
                  if (i_lo_we) begin
                     r_lo <= i_wr_data;
                  end
               end
            end
            S_ITER: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_is_div) begin
                  r_rem             <= w_rem_next;
                  r_acc[WIDTH-1:0]  <= {r_acc[WIDTH-2:0], w_ge};
               end else begin
                  r_acc <= w_mul_next;
               end
            end
            S_FINISH: begin
               if (r_is_div) begin
                  // Divide by zero returns all-ones quotient and the raw dividend.
                  if (r_div_zero) begin
                     r_lo <= '1;
                     r_hi <= r_raw_a;
                  end else begin
                     r_lo <= w_quo;
                     r_hi <= w_rem;
                  end
               end else begin
                  r_hi <= w_prod[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod[WIDTH-1:0];
               end
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   assign o_hi   = r_hi;
   assign o_lo   = r_lo;
   assign o_busy = w_busy;
   assign o_done = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized bench for mult_div_unit, checked against an
// arithmetic reference model of the HI/LO results.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        hi_we = 1'b0;
   logic        lo_we = 1'b0;
   logic [31:0] wr_data = '0;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int n_cmp  = 0;
   int n_fail = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .i_clk       (clk),
      .i_reset_n   (reset_n),
      .i_start     (start),
      .i_op        (op),
      .i_operand_a (a),
      .i_operand_b (b),
      .i_hi_we     (hi_we),
      .i_lo_we     (lo_we),
      .i_wr_data   (wr_data),
      .o_hi        (hi),
      .o_lo        (lo),
      .o_busy      (busy),
      .o_done      (done)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain arithmetic on the architectural definitions.
   function automatic void model(input logic [1:0] m_op, input logic [31:0] m_a,
                                 input logic [31:0] m_b,
                                 output logic [31:0] eh, output logic [31:0] el);
      longint      sa, sb, sq, sr;
      logic [63:0] p;
      sa = longint'($signed(m_a));
      sb = longint'($signed(m_b));
      eh = '0;
      el = '0;
      case (m_op)
         2'b00: begin
            p  = sa * sb;
            eh = p[63:32];
            el = p[31:0];
         end
         2'b01: begin
            p  = {32'h0, m_a} * {32'h0, m_b};
            eh = p[63:32];
            el = p[31:0];
         end
         default: begin
            if (m_b == 32'h0) begin
               el = 32'hFFFF_FFFF;
               eh = m_a;
            end else if (m_op == 2'b10) begin
               sq = sa / sb;
               sr = sa % sb;
               el = sq[31:0];
               eh = sr[31:0];
            end else begin
               el = m_a / m_b;
               eh = m_a % m_b;
            end
         end
      endcase
   endfunction

   // Called and returns at a falling edge. intf_at: cycle at which a stray
   // start+MTHI is pulsed while busy; we_with_start: MTHI/MTLO on the start edge.
   task automatic do_op(input logic [1:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                        input int intf_at, input bit we_with_start, input bit b2b,
                        input string tag);
      logic [31:0] eh, el, pre_hi, pre_lo;
      int edges, busy_cnt;
      model(t_op, t_a, t_b, eh, el);
      pre_hi  = hi;
      pre_lo  = lo;
      start   = 1'b1;
      op      = t_op;
      a       = t_a;
      b       = t_b;
      hi_we   = we_with_start;
      lo_we   = we_with_start;
      wr_data = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      edges = 0;
      busy_cnt = 0;
      check({tag, "_busy_rise"}, 64'(busy), 64'd1);
      check({tag, "_start_hold"}, {hi, lo}, {pre_hi, pre_lo});
      while (!done && edges < 40) begin
         if (busy) busy_cnt++;
         if (edges == intf_at) begin
            start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
            hi_we = 1'b1; wr_data = 32'h13;
         end else if (edges == intf_at + 1) begin
            start = 1'b0; hi_we = 1'b0;
         end
         if (edges == 16) check({tag, "_iter_hold"}, {hi, lo}, {pre_hi, pre_lo});
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      start = 1'b0;
      hi_we = 1'b0;
      check({tag, "_latency"}, 64'(edges), 64'd33);
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
      check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      check({tag, "_hi"}, 64'(hi), 64'(eh));
      check({tag, "_lo"}, 64'(lo), 64'(el));
      $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h (model hi=%h lo=%h) edges=%0d",
               tag, t_op, t_a, t_b, hi, lo, eh, el, edges);
      if (!b2b) begin
         @(posedge clk);
         @(negedge clk);
         check({tag, "_done_clear"}, 64'(done), 64'd0);
         check({tag, "_idle"}, 64'(busy), 64'd0);
      end
   endtask

   task automatic mmio(input bit w_hi, input bit w_lo, input logic [31:0] data, input string tag);
      logic [31:0] eh, el;
      eh = w_hi ? data : hi;
      el = w_lo ? data : lo;
      hi_we   = w_hi;
      lo_we   = w_lo;
      wr_data = data;
      @(posedge clk);
      @(negedge clk);
      hi_we = 1'b0;
      lo_we = 1'b0;
      check({tag, "_hi"}, 64'(hi), 64'(eh));
      check({tag, "_lo"}, 64'(lo), 64'(el));
      $display("%s hi_we=%0d lo_we=%0d data=%h -> hi=%h lo=%h", tag, w_hi, w_lo, data, hi, lo);
   endtask

   initial begin
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;
      int          done_seen;

      #1 reset_n = 1'b0;
      #1;
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, 1'b0, "multu_max");
      do_op(2'b00, 32'hFFFF_FFFD, 32'd5,         -1, 1'b0, 1'b0, "mult_neg");
      do_op(2'b00, 32'h8000_0000, 32'h8000_0000, -1, 1'b0, 1'b0, "mult_min");
      do_op(2'b10, 32'hFFFF_FFF9, 32'd2,         -1, 1'b0, 1'b0, "div_neg");
      do_op(2'b11, 32'd100,       32'd7,         -1, 1'b0, 1'b0, "divu");
      do_op(2'b11, 32'h0000_1234, 32'd0,         -1, 1'b0, 1'b0, "divu_zero");
      do_op(2'b10, 32'hFFFF_FF00, 32'd0,         -1, 1'b0, 1'b0, "div_zero_neg");
      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, 1'b0, "div_ovf");
      do_op(2'b10, 32'd7,         32'hFFFF_FFFE, -1, 1'b0, 1'b0, "div_negdiv");

      do_op(2'b01, 32'd6, 32'd7, 5, 1'b0, 1'b0, "interfere");
      check("interfere_hi_exact", 64'(hi), 64'd0);
      check("interfere_lo_exact", 64'(lo), 64'h2A);
      mmio(1'b1, 1'b0, 32'h13, "mthi");
      mmio(1'b0, 1'b1, 32'h77, "mtlo");
      mmio(1'b1, 1'b1, 32'h55, "mthilo");

      do_op(2'b11, 32'd50, 32'd8, -1, 1'b1, 1'b0, "we_with_start");
      do_op(2'b01, 32'd3, 32'd4, 32, 1'b0, 1'b0, "start_in_finish");
      do_op(2'b00, 32'hFFFF_FFFF, 32'd9, -1, 1'b0, 1'b1, "b2b_first");
      do_op(2'b11, 32'd1000, 32'd33, -1, 1'b0, 1'b0, "b2b_second");

      for (int i = 0; i < 24; i++) begin
         r_op = 2'($urandom_range(0, 3));
         r_a  = $urandom;
         r_b  = $urandom;
         case ($urandom_range(0, 7))
            0: r_b = 32'h0;
            1: r_a = 32'h8000_0000;
            2: r_b = 32'hFFFF_FFFF;
            3: r_b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         do_op(r_op, r_a, r_b, -1, 1'b0, 1'b0, $sformatf("rand%0d", i));
      end

      // Asynchronous reset in the middle of an operation.
      mmio(1'b1, 1'b1, 32'hA5A5_A5A5, "pre_rst");
      start = 1'b1; op = 2'b00; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_busy", 64'(busy), 64'd0);
      check("async_rst_done", 64'(done), 64'd0);
      check("async_rst_hi", 64'(hi), 64'd0);
      check("async_rst_lo", 64'(lo), 64'd0);
      $display("async_rst busy=%0d done=%0d hi=%h lo=%h", busy, done, hi, lo);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("async_rst_no_done", 64'(done_seen), 64'd0);
      do_op(2'b11, 32'd9, 32'd3, -1, 1'b0, 1'b0, "post_rst_divu");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit for the MIPS core.
- Sits directly downstream of register_file: operand_a/operand_b come from its data_a/data_b read ports (rs/rt).
- Executes MULT, MULTU, DIV and DIVU over 32 iteration cycles, then holds the results in HI/LO for MFHI/MFLO.
- Also services MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  launch the operation selected by op; sampled at posedge
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- operand_a  input  WIDTH  rs value (multiplicand / dividend)
- operand_b  input  WIDTH  rt value (multiplier / divisor)
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wr_data  input  WIDTH  MTHI/MTLO data
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in flight; used as the core stall request
- done  output  1  one-cycle pulse when HI/LO receive a result

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; hi=0, lo=0, busy=0, done=0; counter and working registers cleared.
  - Applies immediately, including mid-operation. The in-flight result is discarded.
- FSM states: IDLE -> ITER -> FINISH -> IDLE.
- IDLE:
  - start=1 at edge N latches op, |a|, |b| (absolute values only for signed ops), sign flags, and counter=0.
  - Moves to ITER; busy=1 from after edge N.
- ITER (edges N+1 .. N+32), one step per edge:
  - Multiply: shift-add, 2*WIDTH-bit accumulator.
  - Divide: restoring shift-subtract, partial remainder WIDTH+1 bits.
  - At the edge where counter==WIDTH-1, go to FINISH.
- FINISH (edge N+33):
  - Apply sign correction and write HI/LO.
  - busy=0 and done=1 for the cycle after edge N+33.
  - Return to IDLE. done self-clears at the next edge.
- Result rules:
  - MULT/MULTU: {hi,lo} = full 64-bit product, signed or unsigned.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
  - Divide by zero, DIV or DIVU: lo=0xFFFFFFFF, hi=operand_a (raw value as latched); no exception.
- Latency: fixed WIDTH+1 = 33 edges from the start edge to the result write, independent of operand values.
- start while busy=1: ignored; the operation in flight is unaffected.
- hi_we/lo_we:
  - In IDLE with no start: the register takes wr_data at the edge. Both may be asserted together.
  - While busy: ignored.
  - Same edge as an accepted start: start wins, the write is dropped.
- start in the FINISH cycle: ignored; a start is only accepted in IDLE.
- Back-to-back: a start in the cycle done=1 is accepted, so the next operation begins immediately.
- hi/lo hold their values during ITER; they change only at FINISH, on an MTHI/MTLO write, or on reset.

Test Plan:
- Unsigned multiply: MULTU 0xFFFFFFFF*0xFFFFFFFF.
  - busy high for 33 cycles.
  - done at edge+33 with hi=0xFFFFFFFE, lo=0x00000001.
- Signed multiply: MULT 0xFFFFFFFD(-3)*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Signed multiply: MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- Signed divide: DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Unsigned divide: DIVU 100/7 -> lo=0x0000000E, hi=0x00000002.
- Corner divides:
  - DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234.
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Interference:
  - start a MULTU 6*7.
  - At cycle 5, pulse start with DIVU operands and hi_we with wr_data=0x13: both are ignored.
  - Result is hi=0, lo=0x2A at cycle 33.
  - In IDLE, hi_we=1 with wr_data=0x13 -> hi=0x13 next edge; lo unchanged.
- Reset mid-operation:
  - start a MULT, then pull reset_n low asynchronously at cycle 10, between edges.
  - busy, done, hi and lo go to 0 immediately, with no clock edge.
  - After release, no done pulse appears.
  - A fresh DIVU 9/3 gives lo=3, hi=0 after 33 edges.
